// File: rtl/reg_scoreboard_if.sv
// rtl/reg_scoreboard_if.sv - decode, retire and status bundle of the register scoreboard
interface reg_scoreboard_if #(
  parameter int NREG = 32,
  parameter int AW   = 5
);
  logic            dec_valid;
  logic [AW-1:0]   dec_rs;
  logic [AW-1:0]   dec_rd;
  logic            dec_uses_rs;
  logic            dec_uses_rd;
  logic            dec_writes;
  logic            flush;
  logic            wb_valid;
  logic [AW-1:0]   wb_rd;
  logic            dec_stall;
  logic            issue;
  logic [NREG-1:0] pending_mask;
  logic [7:0]      inflight_cnt;
  logic            err_underflow;

  modport master (
    output dec_valid, dec_rs, dec_rd, dec_uses_rs, dec_uses_rd, dec_writes,
    output flush, wb_valid, wb_rd,
    input  dec_stall, issue, pending_mask, inflight_cnt, err_underflow
  );

  modport slave (
    input  dec_valid, dec_rs, dec_rd, dec_uses_rs, dec_uses_rd, dec_writes,
    input  flush, wb_valid, wb_rd,
    output dec_stall, issue, pending_mask, inflight_cnt, err_underflow
  );
endinterface

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - per-register pending-write counters that stall decode on hazards
module reg_scoreboard #(
  parameter int NREG           = 32,
  parameter int AW             = 5,
  parameter int CW             = 2,
  parameter int ZERO_HARDWIRED = 1
) (
  input  logic             clk,
  input  logic             rst,
  reg_scoreboard_if.slave  bus
);
  localparam logic [CW-1:0] CNT_MAX = '1;

  logic [CW-1:0] cnt [NREG];
  logic [7:0]    inflight_q;
  logic          err_q;
  logic [CW-1:0] cnt_rs;
  logic [CW-1:0] cnt_rd;
  logic [CW-1:0] cnt_wb;
  logic          hazard;
  logic          structural;
  logic          stall;
  logic          issue;
  logic          mark;
  logic          retire_req;
  logic          retire;
  logic [NREG-1:0] pend;

  always_comb begin
    cnt_rs     = cnt[bus.dec_rs];
    cnt_rd     = cnt[bus.dec_rd];
    cnt_wb     = cnt[bus.wb_rd];
    hazard     = (bus.dec_uses_rs && (cnt_rs != '0)) || (bus.dec_uses_rd && (cnt_rd != '0));
    structural = bus.dec_writes && (cnt_rd == CNT_MAX);
    // Gating with rst keeps both handshake outputs quiet while reset is held.
    stall      = rst && bus.dec_valid && !bus.flush && (hazard || structural);
    issue      = rst && bus.dec_valid && !bus.flush && !stall;
    mark       = issue && bus.dec_writes && !((ZERO_HARDWIRED != 0) && (bus.dec_rd == '0));
    retire_req = bus.wb_valid && !bus.flush && !((ZERO_HARDWIRED != 0) && (bus.wb_rd == '0));
    retire     = retire_req && (cnt_wb != '0);
  end

  always_comb begin
    pend = '0;
    for (int i = 0; i < NREG; i++) begin
      pend[i] = (cnt[i] != '0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        cnt[i] <= '0;
      end
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (retire_req && (cnt_wb == '0)) begin
        err_q <= 1'b1;
      end
      if (bus.flush) begin
        for (int i = 0; i < NREG; i++) begin
          cnt[i] <= '0;
        end
        inflight_q <= '0;
      end else begin
        // A mark and a retire landing on the same register cancel out.
        for (int i = 0; i < NREG; i++) begin
          if (mark && (bus.dec_rd == AW'(i)) && !(retire && (bus.wb_rd == AW'(i)))) begin
            cnt[i] <= cnt[i] + CW'(1);
          end else if (retire && (bus.wb_rd == AW'(i)) && !(mark && (bus.dec_rd == AW'(i)))) begin
            cnt[i] <= cnt[i] - CW'(1);
          end
        end
        case ({mark, retire})
          2'b10:   inflight_q <= inflight_q + 8'd1;
          2'b01:   inflight_q <= inflight_q - 8'd1;
          default: inflight_q <= inflight_q;
        endcase
      end
    end
  end

  assign bus.dec_stall     = stall;
  assign bus.issue         = issue;
  assign bus.pending_mask  = pend;
  assign bus.inflight_cnt  = inflight_q;
  assign bus.err_underflow = err_q;
endmodule

// File: tb/tb_reg_scoreboard.sv
// tb/tb_reg_scoreboard.sv - directed self-checking bench for reg_scoreboard
module tb_reg_scoreboard;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  reg_scoreboard_if #(.NREG(32), .AW(5)) bus ();

  reg_scoreboard #(.NREG(32), .AW(5), .CW(2), .ZERO_HARDWIRED(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rd,
                       input logic urs, input logic urd, input logic wr,
                       input logic fl, input logic wv, input logic [4:0] wrd);
    bus.dec_valid   = v;
    bus.dec_rs      = rs;
    bus.dec_rd      = rd;
    bus.dec_uses_rs = urs;
    bus.dec_uses_rd = urd;
    bus.dec_writes  = wr;
    bus.flush       = fl;
    bus.wb_valid    = wv;
    bus.wb_rd       = wrd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(1, 0, 5, 0, 0, 1, 0, 0, 0);
    repeat (3) @(negedge clk);
    checks++; if (bus.issue !== 1'b0) begin errors++; $display("FAIL reset_issue: got %b want 0", bus.issue); end
    checks++; if (bus.dec_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", bus.dec_stall); end
    checks++; if (bus.pending_mask !== 32'h0) begin errors++; $display("FAIL reset_mask: got %h want 0", bus.pending_mask); end
    checks++; if (bus.inflight_cnt !== 8'd0) begin errors++; $display("FAIL reset_inflight: got %0d want 0", bus.inflight_cnt); end
    tick();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++; if (bus.err_underflow !== 1'b0) begin errors++; $display("FAIL idle_err: got %b want 0", bus.err_underflow); end
    checks++; if (bus.pending_mask !== 32'h0) begin errors++; $display("FAIL idle_mask: got %h want 0", bus.pending_mask); end
    tick();
  endtask

  task automatic test_raw();
    drive(1, 0, 5, 0, 0, 1, 0, 0, 0);
    @(negedge clk);
    checks++; if (bus.issue !== 1'b1) begin errors++; $display("FAIL raw_write_issue: got %b want 1", bus.issue); end
    tick();
    drive(1, 5, 0, 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++; if (bus.dec_stall !== 1'b1) begin errors++; $display("FAIL raw_stall: got %b want 1", bus.dec_stall); end
    checks++; if (bus.pending_mask !== 32'h20) begin errors++; $display("FAIL raw_mask: got %h want 20", bus.pending_mask); end
    tick();
    drive(1, 5, 0, 1, 0, 0, 0, 1, 5);
    @(negedge clk);
    checks++; if (bus.dec_stall !== 1'b1) begin errors++; $display("FAIL raw_no_bypass: got %b want 1", bus.dec_stall); end
    tick();
    drive(1, 5, 0, 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++; if (bus.issue !== 1'b1) begin errors++; $display("FAIL raw_release_issue: got %b want 1", bus.issue); end
    checks++; if (bus.inflight_cnt !== 8'd0) begin errors++; $display("FAIL raw_inflight: got %0d want 0", bus.inflight_cnt); end
    tick();
  endtask

  task automatic test_simultaneous();
    drive(1, 0, 7, 0, 0, 1, 0, 0, 0);
    tick();
    drive(1, 0, 7, 0, 0, 1, 0, 1, 7);
    @(negedge clk);
    checks++; if (bus.issue !== 1'b1) begin errors++; $display("FAIL simul_issue: got %b want 1", bus.issue); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++; if (bus.pending_mask !== 32'h80) begin errors++; $display("FAIL simul_mask: got %h want 80", bus.pending_mask); end
    checks++; if (bus.inflight_cnt !== 8'd1) begin errors++; $display("FAIL simul_inflight: got %0d want 1", bus.inflight_cnt); end
    drive(0, 0, 0, 0, 0, 0, 0, 1, 7);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++; if (bus.inflight_cnt !== 8'd0) begin errors++; $display("FAIL simul_drain: got %0d want 0", bus.inflight_cnt); end
    tick();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 9, 0, 0, 1, 0, 0, 0);
      @(negedge clk);
      checks++; if (bus.issue !== 1'b1) begin errors++; $display("FAIL sat_issue%0d: got %b want 1", i, bus.issue); end
      tick();
    end
    drive(1, 0, 9, 0, 0, 1, 0, 0, 0);
    @(negedge clk);
    checks++; if (bus.dec_stall !== 1'b1) begin errors++; $display("FAIL sat_stall: got %b want 1", bus.dec_stall); end
    checks++; if (bus.inflight_cnt !== 8'd3) begin errors++; $display("FAIL sat_full: got %0d want 3", bus.inflight_cnt); end
    tick();
    drive(1, 0, 9, 0, 0, 1, 0, 1, 9);
    @(negedge clk);
    checks++; if (bus.dec_stall !== 1'b1) begin errors++; $display("FAIL sat_retire_cycle: got %b want 1", bus.dec_stall); end
    tick();
    drive(1, 0, 9, 0, 0, 1, 0, 0, 0);
    @(negedge clk);
    checks++; if (bus.issue !== 1'b1) begin errors++; $display("FAIL sat_reissue: got %b want 1", bus.issue); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++; if (bus.inflight_cnt !== 8'd3) begin errors++; $display("FAIL sat_inflight: got %0d want 3", bus.inflight_cnt); end
    drive(0, 0, 0, 0, 0, 0, 0, 1, 9);
    repeat (3) tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++; if (bus.pending_mask !== 32'h0) begin errors++; $display("FAIL sat_drain: got %h want 0", bus.pending_mask); end
    tick();
  endtask

  task automatic test_zero_underflow();
    drive(1, 0, 0, 0, 0, 1, 0, 0, 0);
    @(negedge clk);
    checks++; if (bus.dec_stall !== 1'b0) begin errors++; $display("FAIL r0_stall: got %b want 0", bus.dec_stall); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    @(negedge clk);
    checks++; if (bus.pending_mask !== 32'h0) begin errors++; $display("FAIL r0_mask: got %h want 0", bus.pending_mask); end
    checks++; if (bus.inflight_cnt !== 8'd0) begin errors++; $display("FAIL r0_inflight: got %0d want 0", bus.inflight_cnt); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 4);
    @(negedge clk);
    checks++; if (bus.err_underflow !== 1'b0) begin errors++; $display("FAIL r0_retire_err: got %b want 0", bus.err_underflow); end
    tick();
    drive(1, 0, 2, 0, 0, 1, 0, 0, 0);
    @(negedge clk);
    checks++; if (bus.err_underflow !== 1'b1) begin errors++; $display("FAIL underflow_set: got %b want 1", bus.err_underflow); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 2);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++; if (bus.err_underflow !== 1'b1) begin errors++; $display("FAIL underflow_sticky: got %b want 1", bus.err_underflow); end
    checks++; if (bus.inflight_cnt !== 8'd0) begin errors++; $display("FAIL underflow_inflight: got %0d want 0", bus.inflight_cnt); end
    tick();
  endtask

  task automatic test_flush();
    drive(1, 0, 3, 0, 0, 1, 0, 0, 0);
    tick();
    drive(1, 0, 4, 0, 0, 1, 0, 0, 0);
    tick();
    drive(1, 0, 10, 0, 0, 1, 0, 0, 0);
    tick();
    drive(1, 3, 11, 1, 0, 1, 1, 1, 3);
    @(negedge clk);
    checks++; if (bus.pending_mask !== 32'h418) begin errors++; $display("FAIL flush_pre_mask: got %h want 418", bus.pending_mask); end
    checks++; if (bus.issue !== 1'b0) begin errors++; $display("FAIL flush_issue: got %b want 0", bus.issue); end
    checks++; if (bus.dec_stall !== 1'b0) begin errors++; $display("FAIL flush_stall: got %b want 0", bus.dec_stall); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++; if (bus.pending_mask !== 32'h0) begin errors++; $display("FAIL flush_mask: got %h want 0", bus.pending_mask); end
    checks++; if (bus.inflight_cnt !== 8'd0) begin errors++; $display("FAIL flush_inflight: got %0d want 0", bus.inflight_cnt); end
    checks++; if (bus.err_underflow !== 1'b1) begin errors++; $display("FAIL flush_err: got %b want 1", bus.err_underflow); end
    tick();
  endtask

  task automatic test_reset_mid();
    drive(1, 0, 12, 0, 0, 1, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (bus.pending_mask !== 32'h1000) begin errors++; $display("FAIL mid_pre_mask: got %h want 1000", bus.pending_mask); end
    rst = 1'b0;
    #1;
    checks++; if (bus.pending_mask !== 32'h0) begin errors++; $display("FAIL mid_async_mask: got %h want 0", bus.pending_mask); end
    checks++; if (bus.err_underflow !== 1'b0) begin errors++; $display("FAIL mid_async_err: got %b want 0", bus.err_underflow); end
    tick();
    rst = 1'b1;
    drive(1, 12, 12, 1, 0, 1, 0, 0, 0);
    @(negedge clk);
    checks++; if (bus.issue !== 1'b1) begin errors++; $display("FAIL mid_post_issue: got %b want 1", bus.issue); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++; if (bus.inflight_cnt !== 8'd1) begin errors++; $display("FAIL mid_post_inflight: got %0d want 1", bus.inflight_cnt); end
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_raw();
    test_simultaneous();
    test_saturation();
    test_zero_underflow();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Register-dependency scoreboard and issue controller for the decode stage of the vectorial CPU pipeline.
- Tracks in-flight writes to each register of the register bank and stalls decode when a source or destination register has a pending write.
- Releases the stall when the write-back stage retires the write.
- Sits between instruction fetch/decode and the decode stage; the write-back stage drives the retire port.

Parameters:
- NREG, 32, number of architectural registers.
- AW, 5, register address width.
- CW, 2, width of each per-register pending-write counter; saturates at 2^CW-1.
- ZERO_HARDWIRED, 1, when 1 register 0 is never marked pending.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- dec_valid  in  1  decode holds a valid instruction.
- dec_rs  in  AW  first source register, read on data port A.
- dec_rd  in  AW  second source / destination register, read on data port B.
- dec_uses_rs  in  1  instruction reads dec_rs.
- dec_uses_rd  in  1  instruction reads dec_rd.
- dec_writes  in  1  instruction will write dec_rd at write-back.
- flush  in  1  pipeline flush; discards all in-flight writes.
- wb_valid  in  1  write-back commits a register write this cycle.
- wb_rd  in  AW  register written by write-back.
- dec_stall  out  1  hold fetch/decode this cycle.
- issue  out  1  instruction advances this cycle.
- pending_mask  out  NREG  bit i = counter i nonzero.
- inflight_cnt  out  8  total pending writes across all registers.
- err_underflow  out  1  sticky flag: retire seen with counter at zero.

Behaviour:
- State: NREG counters cnt[i] (CW bits), inflight_cnt register, err_underflow register. All are cleared to 0 while rst=0 (asynchronous).
- Outputs during reset: dec_stall=0, issue=0, pending_mask=0, inflight_cnt=0, err_underflow=0.
- hazard = (dec_uses_rs & cnt[dec_rs]!=0) | (dec_uses_rd & cnt[dec_rd]!=0).
- structural = dec_writes & cnt[dec_rd]==max.
- dec_stall = dec_valid & !flush & (hazard | structural). Combinational, zero latency.
- issue = dec_valid & !flush & !dec_stall.
- No same-cycle retire bypass. A read of a register retiring in cycle t stalls in t and issues in t+1 at the earliest.
- Mark: issue & dec_writes & !(ZERO_HARDWIRED & dec_rd==0) increments cnt[dec_rd] at the next edge.
- Retire: wb_valid & !flush & !(ZERO_HARDWIRED & wb_rd==0).
  - If cnt[wb_rd]!=0, it decrements cnt[wb_rd].
  - If cnt[wb_rd]==0, the counter is unchanged and err_underflow is set (sticky until reset).
- Mark and retire on the same register in the same cycle: counter unchanged, inflight_cnt unchanged.
- Mark and retire on different registers in the same cycle: both applied.
- inflight_cnt += mark, -= valid retire. Never wraps: NREG*(2^CW-1) ≤ 255 is a legal-configuration requirement.
- flush: all counters and inflight_cnt go to 0 at the next edge. issue=0 and dec_stall=0 that cycle; the same-cycle wb_valid is ignored. err_underflow is not cleared by flush.
- pending_mask and inflight_cnt are driven from registered state (no combinational path from inputs).
- Reset asserted mid-operation: all state clears immediately. After reset release, the first edge with valid stimulus behaves as from power-up.
- The counter array is not a state machine. Per register, the states are IDLE (0) → PENDING (1..max); max blocks further marks of that register.

Test Plan:
- Reset then idle: rst=0 for 3 cycles, then release. Required: pending_mask=0, inflight_cnt=0, dec_stall=0, err_underflow=0.
- RAW stall: issue r5 write (dec_writes=1, dec_rd=5). Next cycle, read rs=5. Required: dec_stall=1 and pending_mask[5]=1 until the cycle after wb_valid with wb_rd=5; issue=1 on that following cycle.
- Simultaneous mark/retire: cnt[7]=1, then issue a write to r7 while wb_rd=7. Required: cnt[7] stays 1, inflight_cnt unchanged, pending_mask[7]=1.
- Saturation: issue 3 writes to r9 (CW=2), then a 4th write to r9. Required: 4th gets dec_stall=1. After one retire of r9, it issues; inflight_cnt=3.
- Zero register and underflow:
  - Write to r0 → pending_mask[0]=0, no stall.
  - wb_valid with wb_rd=4 and cnt[4]=0 → err_underflow=1, held after further traffic.
- Flush: r3, r4, r10 pending, assert flush with dec_valid=1 and wb_valid=1 (wb_rd=3). Required:
  - issue=0 that cycle.
  - Next cycle pending_mask=0 and inflight_cnt=0.
  - err_underflow unchanged.
